square_energy_acc: RTL

- Multi-channel windowed energy accumulator for the ThresholdCutter path. Successor to the single-shot signed square stage.
- Accepts time-multiplexed signed samples tagged with a channel index.
- Squares each sample's magnitude with an iterative shift-add multiplier, then sums the squares per channel over a window of WIN_LEN samples.
- At each window end, emits the channel energy plus a threshold-exceeded flag through a valid/ready handshake.

---
 rtl/square_energy_acc.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/square_energy_acc.sv
// Multi-channel windowed energy accumulator: |x|^2 via iterative shift-add, summed per channel.
// Optional macro SQUARE_ENERGY_MEAN_EN reports the window mean square instead of the raw sum.
module square_energy_acc #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned CH_NUM     = 4,
    parameter int unsigned WIN_LEN    = 64,
    localparam int unsigned CH_W      = (CH_NUM > 1) ? $clog2(CH_NUM) : 1,
    localparam int unsigned ACC_WIDTH = 2 * DATA_WIDTH + $clog2(WIN_LEN)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [CH_W-1:0]       in_ch,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [ACC_WIDTH-1:0]  thresh,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CH_W-1:0]       out_ch,
    output logic [ACC_WIDTH-1:0]  out_energy,
    output logic                  out_over,
    output logic                  busy
);

    localparam int unsigned PROD_W = 2 * DATA_WIDTH;
    localparam int unsigned CNT_W  = $clog2(WIN_LEN);
    localparam int unsigned BIT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        ACC,
        OUT
    } state_t;

    state_t state_q, state_d;

    logic [CH_W-1:0]       ch_q, ch_d;
    logic [DATA_WIDTH-1:0] mag_q, mag_d;
    logic [PROD_W-1:0]     prod_q, prod_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic [ACC_WIDTH-1:0]  acc_q [CH_NUM];
    logic [ACC_WIDTH-1:0]  acc_d [CH_NUM];
    logic [CNT_W-1:0]      cnt_q [CH_NUM];
    logic [CNT_W-1:0]      cnt_d [CH_NUM];

    logic [CH_W-1:0]       out_ch_d;
    logic [ACC_WIDTH-1:0]  out_energy_d;
    logic                  out_over_d;
    logic                  out_valid_d;
    logic                  in_ready_d;
    logic                  busy_d;

    logic [DATA_WIDTH-1:0] in_mag;
    logic                  in_ch_ok;
    logic [ACC_WIDTH-1:0]  sum_w;
    logic [ACC_WIDTH-1:0]  energy_w;

    // Two's complement magnitude; the most negative value maps to 2^(DATA_WIDTH-1) unsigned
    assign in_mag   = in_data[DATA_WIDTH-1] ? (~in_data + DATA_WIDTH'(1)) : in_data;
    assign in_ch_ok = 32'(in_ch) < CH_NUM;

    // Next-state and datapath update
    always_comb begin
        state_d      = state_q;
        ch_d         = ch_q;
        mag_d        = mag_q;
        prod_d       = prod_q;
        bit_d        = bit_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        out_ch_d     = out_ch;
        out_energy_d = out_energy;
        out_over_d   = out_over;
        sum_w        = acc_q[ch_q] + ACC_WIDTH'(prod_q);
`ifdef SQUARE_ENERGY_MEAN_EN
        energy_w     = sum_w >> CNT_W;
`else
        energy_w     = sum_w;
`endif

        case (state_q)
            IDLE: begin
                // Out-of-range channels are consumed without touching any state
                if (in_valid && in_ready && in_ch_ok) begin
                    ch_d    = in_ch;
                    mag_d   = in_mag;
                    prod_d  = '0;
                    bit_d   = '0;
                    state_d = MUL;
                end
            end
            MUL: begin
                if (mag_q[bit_q]) begin
                    prod_d = prod_q + (PROD_W'(mag_q) << bit_q);
                end
                bit_d = bit_q + BIT_W'(1);
                if (bit_q == BIT_W'(DATA_WIDTH - 1)) begin
                    state_d = ACC;
                end
            end
            ACC: begin
                acc_d[ch_q] = sum_w;
                cnt_d[ch_q] = cnt_q[ch_q] + CNT_W'(1);
                if (cnt_q[ch_q] == CNT_W'(WIN_LEN - 1)) begin
                    out_energy_d = energy_w;
                    out_ch_d     = ch_q;
                    out_over_d   = energy_w > thresh;
                    acc_d[ch_q]  = '0;
                    cnt_d[ch_q]  = '0;
                    state_d      = OUT;
                end else begin
                    state_d = IDLE;
                end
            end
            OUT: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d  = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
        out_valid_d = (state_d == OUT);
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            ch_q       <= '0;
            mag_q      <= '0;
            prod_q     <= '0;
            bit_q      <= '0;
            for (int i = 0; i < int'(CH_NUM); i++) begin
                acc_q[i] <= '0;
                cnt_q[i] <= '0;
            end
            in_ready   <= 1'b1;
            busy       <= 1'b0;
            out_valid  <= 1'b0;
            out_ch     <= '0;
            out_energy <= '0;
            out_over   <= 1'b0;
        end else begin
            state_q    <= state_d;
            ch_q       <= ch_d;
            mag_q      <= mag_d;
            prod_q     <= prod_d;
            bit_q      <= bit_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            in_ready   <= in_ready_d;
            busy       <= busy_d;
            out_valid  <= out_valid_d;
            out_ch     <= out_ch_d;
            out_energy <= out_energy_d;
            out_over   <= out_over_d;
        end
    end

endmodule
